spi_slave: RTL
==============

// Module: spi_slave
// PURPOSE
//   SPI responder (slave) for the spi_master initiator; one slave-select line, one frame of C bits per SS assertion.
//   Oversamples SPI_CLK/SPI_SS/MOSI in the CLK_IN domain, receives MOSI LSB-first, returns MISO MSB-first.
//   Under this bit ordering, master dout equals slave din, and slave dout equals master din.
//   Sits on FPGA-side peripherals that must answer a host-side spi_master.
// PARAMETERS
//   C           32  frame length in bits (C >= 2)
//   SYNC_STAGES 2   flops in each input synchronizer (>= 2)
// PORTS
//   CLK_IN    in   1  system clock; all state on its rising edge
//   RST       in   1  asynchronous, active-high reset
//   SPI_CLK   in   1  serial clock from master (asynchronous to CLK_IN)
//   SPI_SS    in   1  slave select, active low
//   MOSI      in   1  serial data from master
//   MISO      out  1  serial data to master
//   CPOL      in   1  clock polarity; static while SPI_SS low
//   CPHA      in   1  clock phase; static while SPI_SS low
//   din       in   C  response word; captured at frame start
//   dout      out  C  last complete received word
//   valid     out  1  one-cycle pulse: dout updated with a full frame
//   busy      out  1  high while a frame is in progress (synchronized SS low)
//   frame_err out  1  one-cycle pulse: SS released after 1..C-1 sample edges
// BEHAVIOUR
//   Requirement: CLK_IN >= 8x SPI_CLK frequency; SS hold >= 1 SPI_CLK period (spi_master with CLK_RATIO>=4 meets this).
//   Sync: SPI_CLK, SPI_SS, MOSI each pass SYNC_STAGES flops; edges use the last sync stage and one further delay flop.
//   Sample edge: rising edge of (SPI_CLK ^ CPOL ^ CPHA). Shift edge: the opposite edge.
//   Reset: MISO=0, dout=0, valid=0, busy=0, frame_err=0, bit counter=0, state=WAIT_IDLE.
//   State machine:
//     WAIT_IDLE: ignores all inputs; goes to IDLE when synced SS is high.
//     IDLE: on synced SS falling edge, loads the tx shift register with din and the counter with 0, drives MISO=din[C-1]; goes to SHIFT.
//     SHIFT:
//       On a sample edge, shifts rx right with MOSI into bit C-1 and increments the counter.
//       On a shift edge, only when counter > 0, shifts tx left and drives MISO with the new MSB.
//       A shift edge before the first sample edge (CPHA=1 lead edge) is ignored.
//       When the counter reaches C, writes dout from rx in the same cycle, pulses valid, goes to DONE.
//       Latency: valid is high no later than SYNC_STAGES+2 CLK_IN cycles after the real C-th sample edge.
//     DONE: ignores extra SPI_CLK edges; MISO=0; goes to IDLE on synced SS rising edge.
//   Bit order: rx bit 0 holds the first MOSI bit received. tx sends din[C-1] first.
//   Early SS release in SHIFT:
//     counter == 0: returns to IDLE silently.
//     counter 1..C-1: pulses frame_err, leaves dout unchanged, no valid; returns to IDLE.
//   Same-cycle sample edge and SS rising edge: the sample is taken first, then SS release is evaluated.
//     If that sample is the C-th, the frame is complete (valid, no frame_err).
//   busy = synced SS low, while in SHIFT or DONE; 0 in IDLE and WAIT_IDLE.
//   RST mid-frame: all state is cleared and the FSM enters WAIT_IDLE, so the rest of that frame is ignored.
//   No response occurs until SS is deasserted and asserted again.
//   din changes after frame start do not affect the current frame.
// CONFIGURATION
//   SPI_SLAVE_MISO_TRISTATE_EN
//     Defined: MISO = 1'bz whenever synced SS is high or state is WAIT_IDLE, so several slaves can share MISO.
//     Undefined: MISO is always driven; 0 when not in SHIFT.
// TESTING
//   1 Mode 0, C=32, master CLK_RATIO=8.
//     Master din=32'hA5A5_0F0F, slave din=32'h1234_5678 -> slave dout=A5A5_0F0F, one valid pulse, master dout=1234_5678.
//   2 All four CPOL/CPHA modes, master din=32'h8000_0001, slave din=32'hDEAD_BEEF.
//     -> Exchange is exact in every mode; no frame_err.
//   3 SS released after 5 SPI_CLK cycles -> one frame_err pulse, no valid, dout keeps previous value.
//     The next full frame completes normally.
//   4 40 clocks in one SS window -> valid after the 32nd sample only; dout = first 32 bits; MISO=0 for clocks 33..40.
//   5 RST pulsed after 10 bits -> outputs at reset values; remaining 22 bits ignored.
//     The following frame, slave din=32'h0000_00FF, is exchanged correctly.
//   6 Back-to-back frames (SS high 1 SPI_CLK period between them) -> two valid pulses with correct dout each.
//     With SPI_SLAVE_MISO_TRISTATE_EN defined, MISO is Z between the frames.

Source files
------------

// File: rtl/spi_slave.sv
//============================================================================
// Module  : spi_slave
// Brief   : Oversampled SPI responder; receives MOSI LSB-first, returns MISO
//           MSB-first, one C-bit frame per slave-select assertion.
//           Optional feature macro: SPI_SLAVE_MISO_TRISTATE_EN (shared MISO).
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module spi_slave #(
    parameter int C           = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic         CLK_IN,
    input  logic         RST,
    input  logic         SPI_CLK,
    input  logic         SPI_SS,
    input  logic         MOSI,
    output logic         MISO,
    input  logic         CPOL,
    input  logic         CPHA,
    input  logic [C-1:0] din,
    output logic [C-1:0] dout,
    output logic         valid,
    output logic         busy,
    output logic         frame_err
);

    localparam int CW = $clog2(C + 1);
    localparam logic [CW-1:0] c_CNT_LAST = CW'(C - 1);
    localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_WAIT_IDLE = 2'd0,
        ST_IDLE      = 2'd1,
        ST_SHIFT     = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_ss_d;

    logic [C-2:0]           r_tx;
    logic [C-2:0]           r_rx;
    logic [CW-1:0]          r_cnt;
    logic                   r_miso;
    logic [C-1:0]           r_dout;
    logic                   r_valid;
    logic                   r_frame_err;

    logic                   w_sclk;
    logic                   w_ss;
    logic                   w_mosi;
    logic                   w_phase;
    logic                   w_sck_now;
    logic                   w_sck_prev;
    logic                   w_sample;
    logic                   w_shift;
    logic                   w_ss_fall;
    logic                   w_ss_rise;
    logic                   w_last;
    logic [CW-1:0]          w_cnt_after;
    logic [C-1:0]           w_rx_full;

    // SS synchronizer clears to 0 so a reset mid-frame waits for a real release
    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            r_sclk_sync <= '0;
            r_ss_sync   <= '0;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_ss_d      <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SPI_CLK};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SPI_SS};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
            r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
            r_ss_d      <= r_ss_sync[SYNC_STAGES-1];
        end
    end

    assign w_sclk     = r_sclk_sync[SYNC_STAGES-1];
    assign w_ss       = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
    assign w_phase    = CPOL ^ CPHA;
    assign w_sck_now  = w_sclk ^ w_phase;
    assign w_sck_prev = r_sclk_d ^ w_phase;
    assign w_sample   = w_sck_now & ~w_sck_prev;
    assign w_shift    = ~w_sck_now & w_sck_prev;
    assign w_ss_fall  = ~w_ss & r_ss_d;
    assign w_ss_rise  = w_ss & ~r_ss_d;

    assign w_last      = w_sample && (r_cnt == c_CNT_LAST);
    assign w_cnt_after = w_sample ? (r_cnt + c_CNT_ONE) : r_cnt;
    assign w_rx_full   = {w_mosi, r_rx};

    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            r_state <= ST_WAIT_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A C-th sample coinciding with SS release still completes, so go straight to IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_WAIT_IDLE: if (w_ss)      w_state_next = ST_IDLE;
            ST_IDLE:      if (w_ss_fall) w_state_next = ST_SHIFT;
            ST_SHIFT: begin
                if (w_ss_rise)   w_state_next = ST_IDLE;
                else if (w_last) w_state_next = ST_DONE;
            end
            ST_DONE:      if (w_ss_rise) w_state_next = ST_IDLE;
            default:      w_state_next = ST_WAIT_IDLE;
        endcase
    end

    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            r_tx        <= '0;
            r_rx        <= '0;
            r_cnt       <= '0;
            r_miso      <= 1'b0;
            r_dout      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_ss_fall) begin
                        r_tx   <= din[C-2:0];
                        r_cnt  <= '0;
                        r_miso <= din[C-1];
                    end else begin
                        r_miso <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (w_sample) begin
                        r_rx  <= w_rx_full[C-1:1];
                        r_cnt <= w_cnt_after;
                    end
                    if (w_last) begin
                        r_dout  <= w_rx_full;
                        r_valid <= 1'b1;
                        r_miso  <= 1'b0;
                    end else if (w_ss_rise) begin
                        r_frame_err <= (w_cnt_after != '0);
                        r_miso      <= 1'b0;
                    end else if (w_shift && (r_cnt != '0)) begin
                        // CPHA=1 lead edge arrives with r_cnt==0 and is skipped here
                        r_tx   <= r_tx << 1;
                        r_miso <= r_tx[C-2];
                    end
                end
                default: begin
                    r_miso <= 1'b0;
                end
            endcase
        end
    end

    assign dout      = r_dout;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign busy      = ((r_state == ST_SHIFT) || (r_state == ST_DONE)) && !w_ss;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign MISO = (w_ss || (r_state == ST_WAIT_IDLE)) ? 1'bz : r_miso;
`else
    assign MISO = r_miso;
`endif

endmodule

`default_nettype wire
